sifh_histogram_engine: RTL and testbench
========================================

// Module: sifh_histogram_engine
// PURPOSE
// Parametrised per-pixel dToF histogram builder on a single-port-pair bin RAM (1 write port, 1 read port).
// Per frame: clears all bins, accumulates ACQ_NUM timestamp hits by read-modify-write with saturation
// and hazard forwarding, then scans every pixel histogram and reports its peak bin. Sits between the
// TDC/timestamp front end and the depth-calculation stage.
// PARAMETERS
// PIXELS    4     pixel histograms per RAM (power of two, >=1)
// BINS      64    bins per histogram (power of two, >=2)
// CW        12    bin count width; counts saturate at 2^CW-1
// ACQ_NUM   1024  hits accepted per frame before scan (>=1)
// PW = max(1,$clog2(PIXELS)), BW = $clog2(BINS), AW = PW+BW (derived localparams; address = {pixel,bin})
// PORTS
// clk        in   1    clock, all logic on rising edge
// res        in   1    asynchronous, active-high reset
// start      in   1    1-cycle pulse: begin frame; ignored unless state is IDLE
// in_valid   in   1    hit present
// in_ready   out  1    hit accepted when in_valid & in_ready
// in_pixel   in   PW   pixel index of hit
// in_bin     in   BW   bin index of hit
// ram_we     out  1    RAM write enable
// ram_waddr  out  AW   RAM write address
// ram_wdata  out  CW   RAM write data
// ram_re     out  1    RAM read enable
// ram_raddr  out  AW   RAM read address
// ram_rdata  in   CW   RAM read data, valid exactly 1 cycle after ram_re (read-first on same-address write)
// pk_valid   out  1    1-cycle strobe: peak result for one pixel
// pk_pixel   out  PW   pixel of result
// pk_bin     out  BW   bin with largest count
// pk_count   out  CW   count in that bin
// busy       out  1    high in any state except IDLE
// done       out  1    1-cycle pulse when frame complete
// BEHAVIOUR
// Reset: state IDLE; all outputs 0; hit counter, address counters, pipeline valids, max trackers cleared.
// States: IDLE -start-> CLEAR -last addr written-> ACCUM -ACQ_NUM hits accepted & pipe empty-> SCAN
//   -last pixel reported-> DONE -> IDLE (1 cycle). No other transitions; start outside IDLE has no effect.
// CLEAR: ram_we=1, ram_wdata=0, ram_waddr = 0..PIXELS*BINS-1, one per cycle; in_ready=0; takes PIXELS*BINS cycles.
// ACCUM: in_ready=1 until ACQ_NUM-th hit accepted, then 0 (the ACQ_NUM-th acceptance cycle itself has in_ready=1).
//   Stage 1 (accept cycle t): ram_re=1, ram_raddr={in_pixel,in_bin}; address latched into stage 2.
//   Stage 2 (cycle t+1): new = (old==2^CW-1) ? old : old+1; ram_we=1, ram_waddr=latched addr, ram_wdata=new.
//   old = ram_rdata, EXCEPT when the stage-2 address equals the address written in cycle t (back-to-back hit
//   on same bin): old = value written in cycle t (forwarded). Hits 2+ cycles apart need no forwarding.
//   Throughput 1 hit/cycle; hit-to-write latency 1 cycle; in_valid while in_ready=0 is not consumed.
//   Leaves ACCUM the cycle after the final stage-2 write.
// SCAN: reads addresses 0..PIXELS*BINS-1 sequentially, 1/cycle; compares data on return (1-cycle lag).
//   Per pixel: max tracker starts at (bin 0, count of bin 0); replaced only on strictly greater count, so ties
//   keep the lowest bin. One cycle after the last bin of a pixel's data returns: pk_valid=1 with pixel/bin/count.
//   All-zero histogram reports bin 0, count 0. Exactly PIXELS pk_valid strobes per frame, ascending pixel.
//   pk_pixel/pk_bin/pk_count hold their values until the next strobe. ram_we=0 throughout SCAN.
// DONE: done=1 for one cycle, busy=0 the following cycle.
// res asserted mid-frame: immediate return to IDLE, all outputs 0; partial RAM contents are left as-is
//   (next frame's CLEAR overwrites them).
// Width rules: hit counter $clog2(ACQ_NUM+1) bits; address counter AW+1 bits to detect terminal count.
// TESTING
// PIXELS=2,BINS=8: start -> ram_we high 16 cycles, waddr 0..15, wdata 0, then in_ready=1; busy high throughout.
// ACQ_NUM=4, hits (1,3) on 4 consecutive cycles -> writes 1,2,3,4 to addr 11; pk for pixel1 = bin3 count4.
// CW=4, 20 hits to (0,5) with gaps of 1 idle cycle -> final addr 5 = 15; no wrap to 0.
// Pixel0 bins 2 and 6 each hit 3 times, others fewer -> pk_pixel=0, pk_bin=2, pk_count=3; pixel with no hits -> bin 0 count 0.
// start pulse during ACCUM -> ignored, hit count and frame unaffected; exactly PIXELS pk_valid then one done pulse.
// res high for 1 cycle mid-ACCUM -> outputs 0, IDLE; following start runs full CLEAR and a correct frame.

Source files
------------

// File: rtl/sifh_histogram_engine.sv
// Purpose: per-frame dToF histogram builder; clears a {pixel,bin} bin RAM, accumulates hits, reports each pixel's peak bin.
// Latency: hit-to-write 1 cycle; peak strobe 1 cycle after a pixel's last bin returns from the RAM.
// Backpressure: in_ready high only in ACCUM until ACQ_NUM hits are taken; 1 hit/cycle sustained, no stalls inside the pipe.
//
// Ports:
//   clk, res              clock (rising edge), asynchronous active-high reset
//   start                 frame start pulse, honoured only while idle
//   in_valid/in_ready     hit handshake; in_pixel/in_bin give the hit's histogram address
//   ram_we/waddr/wdata    bin RAM write port (CLEAR zeroes, ACCUM read-modify-write)
//   ram_re/raddr/rdata    bin RAM read port, data returns one cycle after ram_re
//   pk_valid/pixel/bin/count  one strobe per pixel with its peak bin; values held between strobes
//   busy, done            frame in progress / one-cycle frame-complete pulse
module sifh_histogram_engine #(
    parameter int PIXELS  = 4,
    parameter int BINS    = 64,
    parameter int CW      = 12,
    parameter int ACQ_NUM = 1024,
    localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1,
    localparam int BW = $clog2(BINS),
    localparam int AW = PW + BW
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_pixel,
    input  logic [BW-1:0] in_bin,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [CW-1:0] ram_wdata,
    output logic          ram_re,
    output logic [AW-1:0] ram_raddr,
    input  logic [CW-1:0] ram_rdata,
    output logic          pk_valid,
    output logic [PW-1:0] pk_pixel,
    output logic [BW-1:0] pk_bin,
    output logic [CW-1:0] pk_count,
    output logic          busy,
    output logic          done
);

    localparam int              HW        = $clog2(ACQ_NUM + 1);
    localparam int              NADDR     = PIXELS * BINS;
    localparam logic [AW:0]     LAST_ADDR = (AW+1)'(NADDR - 1);
    localparam logic [HW-1:0]   HIT_MAX   = HW'(ACQ_NUM);
    localparam logic [CW-1:0]   CNT_SAT   = '1;
    localparam logic [BW-1:0]   LAST_BIN  = BW'(BINS - 1);
    localparam logic [PW-1:0]   LAST_PIX  = PW'(PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Shared sequential address counter for CLEAR writes and SCAN reads;
    // one extra bit so SCAN can tell it has issued the last read.
    logic [AW:0]    addr_cnt;
    logic [HW-1:0]  hit_cnt;

    // Accumulate stage 2: address of the hit whose old count is on ram_rdata.
    logic           acc_vld;
    logic [AW-1:0]  acc_addr;

    // Last cycle's write, used when the RAM's read-first data is stale.
    logic           fwd_vld;
    logic [AW-1:0]  fwd_addr;
    logic [CW-1:0]  fwd_data;

    // Scan read return tracking and per-pixel max tracker.
    logic           rd_vld;
    logic [AW-1:0]  rd_addr;
    logic [BW-1:0]  max_bin;
    logic [CW-1:0]  max_cnt;

    logic           accept;
    logic           scan_rd;
    logic [CW-1:0]  acc_old;
    logic [CW-1:0]  acc_new;
    logic [BW-1:0]  cand_bin;
    logic [CW-1:0]  cand_cnt;

    always_comb begin
        accept  = (state == S_ACCUM) && in_valid && (hit_cnt != HIT_MAX);
        scan_rd = (state == S_SCAN) && (addr_cnt <= LAST_ADDR);

        // A back-to-back hit on the same bin reads the RAM in the very cycle
        // the previous increment is written, so the RAM returns the pre-write
        // value; take the just-written value instead.
        acc_old = (fwd_vld && (fwd_addr == acc_addr)) ? fwd_data : ram_rdata;
        acc_new = (acc_old == CNT_SAT) ? acc_old : acc_old + 1'b1;

        // Tracker after folding in the returning bin: bin 0 restarts it,
        // later bins replace it only on a strictly larger count (ties keep
        // the lowest bin).
        cand_bin = max_bin;
        cand_cnt = max_cnt;
        if (rd_addr[BW-1:0] == '0) begin
            cand_bin = '0;
            cand_cnt = ram_rdata;
        end else if (ram_rdata > max_cnt) begin
            cand_bin = rd_addr[BW-1:0];
            cand_cnt = ram_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: if (addr_cnt == LAST_ADDR) state_nxt = S_ACCUM;
            S_ACCUM: if ((hit_cnt == HIT_MAX) && !acc_vld) state_nxt = S_SCAN;
            S_SCAN:  if (pk_valid && (pk_pixel == LAST_PIX)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_ACCUM) && (hit_cnt != HIT_MAX);
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_raddr = '0;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);

        if (state == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = addr_cnt[AW-1:0];
        end else if ((state == S_ACCUM) && acc_vld) begin
            ram_we    = 1'b1;
            ram_waddr = acc_addr;
            ram_wdata = acc_new;
        end

        if (accept) begin
            ram_re    = 1'b1;
            ram_raddr = {in_pixel, in_bin};
        end else if (scan_rd) begin
            ram_re    = 1'b1;
            ram_raddr = addr_cnt[AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state    <= S_IDLE;
            addr_cnt <= '0;
            hit_cnt  <= '0;
            acc_vld  <= 1'b0;
            acc_addr <= '0;
            fwd_vld  <= 1'b0;
            fwd_addr <= '0;
            fwd_data <= '0;
            rd_vld   <= 1'b0;
            rd_addr  <= '0;
            max_bin  <= '0;
            max_cnt  <= '0;
            pk_valid <= 1'b0;
            pk_pixel <= '0;
            pk_bin   <= '0;
            pk_count <= '0;
        end else begin
            state <= state_nxt;

            if (state != state_nxt) begin
                addr_cnt <= '0;
            end else if ((state == S_CLEAR) || scan_rd) begin
                addr_cnt <= addr_cnt + 1'b1;
            end

            if (state == S_IDLE) begin
                hit_cnt <= '0;
            end else if (accept) begin
                hit_cnt <= hit_cnt + 1'b1;
            end

            acc_vld <= accept;
            if (accept) begin
                acc_addr <= {in_pixel, in_bin};
            end

            fwd_vld  <= ram_we;
            fwd_addr <= ram_waddr;
            fwd_data <= ram_wdata;

            rd_vld  <= scan_rd;
            rd_addr <= addr_cnt[AW-1:0];
            if (rd_vld) begin
                max_bin <= cand_bin;
                max_cnt <= cand_cnt;
            end

            pk_valid <= rd_vld && (rd_addr[BW-1:0] == LAST_BIN);
            if (rd_vld && (rd_addr[BW-1:0] == LAST_BIN)) begin
                pk_pixel <= rd_addr[AW-1:BW];
                pk_bin   <= cand_bin;
                pk_count <= cand_cnt;
            end
        end
    end

endmodule

// File: tb/tb_sifh_histogram_engine.sv
module tb_sifh_histogram_engine;

    localparam int P    = 2;
    localparam int B    = 8;
    localparam int C    = 4;
    localparam int A    = 24;
    localparam int PW   = 1;
    localparam int BW   = 3;
    localparam int AW   = 4;
    localparam int MAXC = 15;

    logic          clk;
    logic          res;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pixel;
    logic [BW-1:0] in_bin;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [C-1:0]  ram_wdata;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [C-1:0]  ram_rdata;
    logic          pk_valid;
    logic [PW-1:0] pk_pixel;
    logic [BW-1:0] pk_bin;
    logic [C-1:0]  pk_count;
    logic          busy;
    logic          done;

    sifh_histogram_engine #(
        .PIXELS (P),
        .BINS   (B),
        .CW     (C),
        .ACQ_NUM(A)
    ) dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pixel (in_pixel),
        .in_bin   (in_bin),
        .ram_we   (ram_we),
        .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata),
        .ram_re   (ram_re),
        .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata),
        .pk_valid (pk_valid),
        .pk_pixel (pk_pixel),
        .pk_bin   (pk_bin),
        .pk_count (pk_count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bin RAM: one write port, one read port, read-first on a same-cycle write.
    logic [C-1:0] mem [0:P*B-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    // Observation log, sampled mid-cycle.
    logic [AW+C-1:0]    wq[$];
    logic [PW+BW+C-1:0] pkq[$];
    int                 done_cnt = 0;
    always @(negedge clk) begin
        if (ram_we)   wq.push_back({ram_waddr, ram_wdata});
        if (pk_valid) pkq.push_back({pk_pixel, pk_bin, pk_count});
        if (done)     done_cnt = done_cnt + 1;
    end

    // Reference model: plain per-pixel/per-bin hit counts with saturation.
    int model [P][B];
    int accepted;
    int wq_base, pk_base, done_base;

    int n_cmp = 0;
    int n_err = 0;

    int f1 [20] = '{2, 6, 2, 6, 4, 2, 6, 4, 1, 8, 8, 9, 9, 10, 10, 12, 12, 13, 13, 15};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        for (int p = 0; p < P; p++)
            for (int b = 0; b < B; b++)
                model[p][b] = 0;
        accepted  = 0;
        pk_base   = pkq.size();
        done_base = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < P*B; i++) begin
            check("clr_we", ram_we, 1);
            check("clr_waddr", ram_waddr, i);
            check("clr_wdata", ram_wdata, 0);
            check("clr_in_ready", in_ready, 0);
            check("clr_busy", busy, 1);
            tick();
        end
        wq_base = wq.size();
        check("accum_in_ready", in_ready, 1);
    endtask

    task automatic hit(input int p, input int b, input int gap);
        logic [31:0] pv, bv;
        pv = p;
        bv = b;
        in_valid = 1'b1;
        in_pixel = pv[PW-1:0];
        in_bin   = bv[BW-1:0];
        check("hit_in_ready", in_ready, accepted < A);
        if (accepted < A) begin
            accepted++;
            if (model[p][b] < MAXC) model[p][b]++;
        end
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic rand_hits(input int n, input int pix_max);
        int p, b;
        p = 0;
        b = 0;
        for (int i = 0; i < n; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 0) begin
                p = $urandom_range(0, pix_max);
                b = $urandom_range(0, B-1);
            end
            hit(p, b, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
    endtask

    task automatic end_frame();
        logic [PW+BW+C-1:0] e;
        int pb, pc, last_pc;
        // An extra offered hit after the quota must not be taken.
        in_valid = 1'b1;
        in_pixel = '0;
        in_bin   = '0;
        check("over_in_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 300 && done_cnt == done_base; i++) tick();
        check("done_pulses", done_cnt - done_base, 1);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("write_count", wq.size() - wq_base, A);
        check("pk_strobes", pkq.size() - pk_base, P);
        last_pc = 0;
        for (int p = 0; p < P; p++) begin
            pb = 0;
            pc = model[p][0];
            for (int b = 1; b < B; b++)
                if (model[p][b] > pc) begin
                    pb = b;
                    pc = model[p][b];
                end
            e = pkq[pk_base + p];
            check("pk_pixel", e[PW+BW+C-1:BW+C], p);
            check("pk_bin", e[BW+C-1:C], pb);
            check("pk_count", e[C-1:0], pc);
            last_pc = pc;
        end
        check("pk_hold", pk_count, last_pc);
        for (int p = 0; p < P; p++)
            for (int b = 0; b < B; b++)
                check("ram_bin", mem[p*B + b], model[p][b]);
        tick();
    endtask

    initial begin
        logic [PW+BW+C-1:0] e;
        res      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        in_bin   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_pk_valid", pk_valid, 0);
        check("rst_done", done, 0);
        res = 1'b0;
        tick();
        check("idle_after_rst", busy, 0);

        // Frame 1: back-to-back same-bin hits, then a peak with a tie.
        begin_frame();
        for (int k = 0; k < 4; k++) hit(1, 3, 0);
        tick();
        for (int k = 0; k < 4; k++)
            check("fwd_write", wq[wq_base + k], (11 << C) | (k + 1));
        for (int i = 0; i < 20; i++) hit(f1[i] / B, f1[i] % B, (i % 3 == 0) ? 1 : 0);
        end_frame();
        e = pkq[pk_base];
        check("tie_p0_bin", e[BW+C-1:C], 2);
        check("tie_p0_cnt", e[C-1:0], 3);
        e = pkq[pk_base + 1];
        check("p1_bin", e[BW+C-1:C], 3);
        check("p1_cnt", e[C-1:0], 4);

        // Frame 2: saturation on (0,5), stray start in ACCUM, pixel 1 empty.
        begin_frame();
        for (int i = 0; i < 20; i++) begin
            hit(0, 5, 0);
            if (i == 9) start = 1'b1;
            tick();
            start = 1'b0;
        end
        rand_hits(4, 0);
        end_frame();
        check("sat_bin5", mem[5], 15);
        e = pkq[pk_base];
        check("sat_pk_bin", e[BW+C-1:C], 5);
        check("sat_pk_cnt", e[C-1:0], 15);
        e = pkq[pk_base + 1];
        check("empty_pk_bin", e[BW+C-1:C], 0);
        check("empty_pk_cnt", e[C-1:0], 0);

        // Frame 3: random hits.
        begin_frame();
        rand_hits(A, P - 1);
        end_frame();

        // Frame 4: reset mid-ACCUM, then a full random frame.
        begin_frame();
        rand_hits(5, P - 1);
        res = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_ram_we", ram_we, 0);
        check("mid_rst_ram_re", ram_re, 0);
        check("mid_rst_pk_valid", pk_valid, 0);
        check("mid_rst_pk_pixel", pk_pixel, 0);
        check("mid_rst_pk_bin", pk_bin, 0);
        check("mid_rst_pk_count", pk_count, 0);
        check("mid_rst_done", done, 0);
        tick();
        res = 1'b0;
        tick();
        begin_frame();
        rand_hits(A, P - 1);
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
